// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - shared constants and FSM encoding for the UART transmit buffer
//
// Purpose: pacing FSM state encoding and default sizing constants used by
//          uart_tx_buffer and its testbench.
// Contents: tx_state_e (IDLE/SEND/HOLD), DEFAULT_DEPTH_LOG2, DEFAULT_GUARD_CYCLES.
package uart_tx_buffer_pkg;

    localparam int DEFAULT_DEPTH_LOG2   = 4;
    localparam int DEFAULT_GUARD_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-array synchronous FIFO with flush and drop indication
//
// Purpose: DEPTH-entry storage with wrapping pointers and a separate level counter.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push_i          write push_data_i when not full and not flushing
//   push_data_i     write data
//   pop_i           advance the read pointer when not empty and not flushing
//   pop_data_o      combinational read of mem[rd_ptr]
//   flush_i         rd_ptr <= wr_ptr, level <= 0; beats push and pop
//   full_o, empty_o status from registered level
//   level_o         number of stored entries
//   drop_o          push attempted while full (never during flush)
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      pop_data_o,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  drop_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]         FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0]         LVL_ONE    = LW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o     = (level_q == FULL_LEVEL);
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Fullness and emptiness are judged on the pre-edge level, so a pop in
    // the same cycle never frees room for a push, and a push into an empty
    // FIFO is never popped in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign drop_o  = push_i && full_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; contents are only visible through level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - elastic character buffer pacing a UART transmitter
//
// Purpose: absorbs bursts of outbound characters and launches one character
//          into the UART whenever it reports idle, with a guard period after
//          every launch to cover the UART status update latency.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_char, in_char_valid character input and one-cycle write strobe
//   in_char_ready         FIFO not full
//   flush                 drop all buffered, not-yet-launched characters
//   tx_data, tx_latch     character and one-cycle start strobe to the UART
//   tx_empty              UART idle
//   level                 buffered character count
//   overflow, clr_overflow sticky drop flag and its clear
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
    parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_char,
    input  logic                in_char_valid,
    output logic                in_char_ready,
    input  logic                flush,
    output logic [7:0]          tx_data,
    output logic                tx_latch,
    input  logic                tx_empty,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow,
    input  logic                clr_overflow
);

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    tx_state_e  state_q;
    logic [3:0] guard_q;
    logic [7:0] tx_data_q;
    logic       tx_latch_q;
    logic       overflow_q, overflow_d;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;
    logic [7:0] fifo_rd_data;
    logic       launch;

    // A flush in the same cycle wins over a launch.
    assign launch = (state_q == ST_IDLE) && !fifo_empty && tx_empty && !flush;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (in_char_valid),
        .push_data_i (in_char),
        .pop_i       (launch),
        .pop_data_o  (fifo_rd_data),
        .flush_i     (flush),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level),
        .drop_o      (fifo_drop)
    );

    assign in_char_ready = !fifo_full;
    assign tx_data       = tx_data_q;
    assign tx_latch      = tx_latch_q;
    assign overflow      = overflow_q;

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Pacing FSM. HOLD lasts GUARD_CYCLES cycles (counter GUARD_CYCLES-1
    // down to 0) and ignores tx_empty, giving a minimum launch spacing of
    // SEND + GUARD_CYCLES + one IDLE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            guard_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_latch_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_latch_q <= 1'b0;
                    if (launch) begin
                        tx_data_q  <= fifo_rd_data;
                        tx_latch_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_latch_q <= 1'b0;
                    guard_q    <= GUARD_LOAD;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    tx_latch_q <= 1'b0;
                    if (guard_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        guard_q <= guard_q - 4'd1;
                    end
                end
                default: begin
                    tx_latch_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Elastic transmit buffer between the ICE bus controller's outbound character stream (tx_char/tx_char_valid) and the UART transmitter (tx_data/tx_latch/tx_empty).
- Absorbs bursts from the controller (response frames, event reports) so that no character is lost while the 3 Mbaud UART serialises.
- Paces the UART so each character is latched only when the transmitter reports idle.
- Reports fill level and a sticky overflow flag for debug.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 characters).
- GUARD_CYCLES, 3, idle cycles after each tx_latch before tx_empty is trusted again; covers UART status update latency. Legal range 1..15.

Ports:
- clk  input  1  system clock (20 MHz).
- reset  input  1  asynchronous, active-high reset.
- in_char  input  8  character from bus controller.
- in_char_valid  input  1  one-cycle strobe; in_char is written when this is high.
- in_char_ready  output  1  high when the FIFO is not full.
- flush  input  1  synchronous clear of all buffered, not-yet-launched characters.
- tx_data  output  8  character presented to the UART.
- tx_latch  output  1  one-cycle strobe to the UART to start transmission.
- tx_empty  input  1  UART transmitter idle and able to accept a character.
- level  output  DEPTH_LOG2+1  current number of buffered characters.
- overflow  output  1  sticky; set when a character is dropped.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, active-high): FIFO empty, read and write pointers 0, level=0, in_char_ready=1, tx_latch=0, tx_data=8'h00, overflow=0, FSM in IDLE, guard counter 0.
- Storage: DEPTH-entry register array. Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. level is a separate counter of width DEPTH_LOG2+1.
- Push: on a clock edge with in_char_valid=1 and level<DEPTH, in_char is written at wr_ptr, wr_ptr increments and level increments.
  - If in_char_valid=1 and level==DEPTH, the character is dropped and overflow is set. This holds even if a pop occurs the same cycle; fullness is judged on the pre-edge level.
- in_char_ready = (level != DEPTH), combinational from registered level.
- FSM states IDLE, SEND, HOLD:
  - IDLE: if level>0 and tx_empty=1 and flush=0, then at the edge: tx_data <= mem[rd_ptr], rd_ptr++, level-- (net of any simultaneous push), go to SEND. Otherwise stay in IDLE.
  - SEND: tx_latch=1 for exactly this one cycle. Next state HOLD, guard counter loaded with GUARD_CYCLES-1.
  - HOLD: tx_latch=0. Counter decrements each cycle; go to IDLE when it reaches 0. tx_empty is ignored throughout HOLD.
- tx_latch is a registered output, high only in SEND. tx_data holds its value until the next launch.
- Latency: with the FIFO empty, the FSM in IDLE and tx_empty=1, a push sampled at edge N gives tx_latch high in the cycle after edge N+1 (2 clocks).
- Minimum launch spacing: 1 + GUARD_CYCLES + 1 cycles (SEND, HOLD, IDLE). Further spacing is set by tx_empty.
- Simultaneous push and pop: both take effect; level is unchanged. With level==0 a push is never popped in the same cycle, because the pop decision uses the pre-edge level.
- Flush: at the edge, rd_ptr <= wr_ptr and level <= 0. A push in the same cycle is discarded and does not set overflow. A character already in SEND/HOLD completes normally. A flush has priority over an IDLE launch in the same cycle.
- Overflow: a set in the same cycle as clr_overflow wins (flag stays 1).
- tx_empty low in IDLE: no launch. The FIFO keeps accepting until full.
- Reset mid-transmission: every state returns to its reset value immediately. The UART itself is not reset by this block.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SEND=2'd1, HOLD=2'd2) and the default depth/guard constants.
- One natural sub-module: sync_fifo (parameterised width/depth; push, pop, full, empty, level, flush). uart_tx_buffer holds the pacing FSM, guard counter and overflow flag.
- Pinned sync_fifo interface, so both engineers build against the same contract:
  - The pop port is a combinational read of mem[rd_ptr].
  - The launching edge advances rd_ptr and simultaneously registers that value into tx_data.
  - flush takes precedence over push inside sync_fifo. A flush-cycle push neither writes nor signals a drop, so uart_tx_buffer does not set overflow for it.

Test Plan:
- Single character: push 8'h41 with tx_empty=1 → tx_latch high exactly 1 cycle, 2 clocks after push, tx_data=8'h41; level back to 0.
- Burst of 16 (8'h00..8'h0F) in consecutive cycles with tx_empty held 0 → level=16, in_char_ready=0, no tx_latch. Then tx_empty=1 → 16 latches in order, spaced exactly GUARD_CYCLES+2=5 cycles apart.
- Overflow: 17 pushes while tx_empty=0 → 17th (8'h10) dropped, overflow=1, level=16. clr_overflow → 0. Clear and set in the same cycle → stays 1.
- Pacing: after a launch, hold tx_empty=0 for 40 cycles → no second latch until tx_empty returns to 1 (and HOLD has elapsed).
- Flush: buffer 5 characters, assert flush during a character's HOLD → that character completes, level=0, no further latches. A push in the flush cycle is not stored and overflow stays 0.
- Async reset asserted mid-HOLD with level=7 → all outputs go to their reset values immediately without waiting for a clock edge. After release, no tx_latch occurs until a new push.
